seven_seg_mux: RTL and testbench

SEVEN_SEG_MUX -- requirements
Module: seven_seg_mux

---
 rtl/seven_seg_mux_pkg.sv | 18 +
 rtl/seven_seg_mux_seg7_decode.sv | 11 +
 rtl/seven_seg_mux.sv | 143 ++++++++++++++
 tb/tb_seven_seg_mux.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_mux_pkg.sv
// Shared constants for the seven-segment multiplexer: active-low polarities
// and the hex glyph table (bit 0 = segment a ... bit 6 = segment g).
package seven_seg_mux_pkg;

  localparam logic ANODE_ON  = 1'b0;
  localparam logic ANODE_OFF = 1'b1;
  localparam logic DP_ON     = 1'b0;
  localparam logic DP_OFF    = 1'b1;

  localparam logic [6:0] SEG_DARK = 7'h7F;

  // Active-low glyphs for 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_seg_mux_seg7_decode.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module seg7_decode
  import seven_seg_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_PATTERNS[nibble];

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed hex display driver with dead time, PWM dimming, blanking,
// leading-zero suppression and frame-atomic double-buffered display data.
module seven_seg_mux
  import seven_seg_mux_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int SLOT_CYCLES = 25000,
  parameter int DEAD_CYCLES = 2,
  parameter int PWM_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  lz_suppress,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   digit,
  output logic                  frame_start
);

  localparam int SLOT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] DEAD_START = SLOT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_DIGITS - 1);

  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;

  logic [4*N_DIGITS-1:0] shadow_value_q, shadow_value_d;
  logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [N_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic [4*N_DIGITS-1:0] live_value_q, live_value_d;
  logic [N_DIGITS-1:0]   live_dp_q, live_dp_d;
  logic [N_DIGITS-1:0]   live_blank_q, live_blank_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [N_DIGITS-1:0]   digit_q, digit_d;
  logic                  frame_start_q, frame_start_d;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic                  hi_zero;
  logic [N_DIGITS-1:0]   dark;
  logic                  anode_on;
  logic [3:0]            cur_nibble;
  logic [6:0]            dec_seg;

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .seg_n  (dec_seg)
  );

  // Live data only changes on the edge that enters slot 0 of a new frame; a
  // load on that same edge bypasses the shadow so it is not lost for a frame.
  always_comb begin
    slot_wrap  = (slot_q == LAST_SLOT);
    frame_wrap = slot_wrap && (idx_q == LAST_IDX);

    slot_d = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d  = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    pwm_d = pwm_q + 1'b1;

    shadow_value_d = load ? value : shadow_value_q;
    shadow_dp_d    = load ? dp    : shadow_dp_q;
    shadow_blank_d = load ? blank : shadow_blank_q;

    live_value_d = frame_wrap ? shadow_value_d : live_value_q;
    live_dp_d    = frame_wrap ? shadow_dp_d    : live_dp_q;
    live_blank_d = frame_wrap ? shadow_blank_d : live_blank_q;
  end

  // Leading-zero suppression scans from the top digit down; digit 0 always shows.
  always_comb begin
    hi_zero = 1'b1;
    dark    = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero & (live_value_q[4*i +: 4] == 4'h0);
      dark[i] = live_blank_q[i] | (lz_suppress & hi_zero & (i != 0));
    end

    cur_nibble = live_value_q[4*idx_q +: 4];
    anode_on   = (slot_q >= DEAD_START) && (pwm_q <= brightness) && !dark[idx_q];

    digit_d       = {N_DIGITS{ANODE_OFF}};
    seg_d         = SEG_DARK;
    dp_n_d        = DP_OFF;
    frame_start_d = (slot_q == '0) && (idx_q == '0);
    if (anode_on) begin
      digit_d[idx_q] = ANODE_ON;
      seg_d          = dec_seg;
      dp_n_d         = live_dp_q[idx_q] ? DP_ON : DP_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q         <= '0;
      idx_q          <= '0;
      pwm_q          <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      live_value_q   <= '0;
      live_dp_q      <= '0;
      live_blank_q   <= '0;
      seg_q          <= SEG_DARK;
      dp_n_q         <= DP_OFF;
      digit_q        <= {N_DIGITS{ANODE_OFF}};
      frame_start_q  <= 1'b0;
    end else begin
      slot_q         <= slot_d;
      idx_q          <= idx_d;
      pwm_q          <= pwm_d;
      shadow_value_q <= shadow_value_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      live_value_q   <= live_value_d;
      live_dp_q      <= live_dp_d;
      live_blank_q   <= live_blank_d;
      seg_q          <= seg_d;
      dp_n_q         <= dp_n_d;
      digit_q        <= digit_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign digit       = digit_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Scoreboard bench for seven_seg_mux with 4 digits, 8-cycle slots, 1 dead cycle.
module tb_seven_seg_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_suppress;
  logic [3:0]  brightness;
  logic        load;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  digit;
  logic        frame_start;

  seven_seg_mux #(
    .N_DIGITS    (4),
    .SLOT_CYCLES (8),
    .DEAD_CYCLES (1),
    .PWM_BITS    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .dp          (dp),
    .blank       (blank),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .load        (load),
    .seg         (seg),
    .dp_n        (dp_n),
    .digit       (digit),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         stamp;
    int         state;
    logic [3:0] digit;
    logic [6:0] seg;
    logic       dp_n;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   tick   = 0;
  int   base   = 0;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] f_seg [4];
  logic       f_dpn [4];
  logic       f_lit [4];
  int         f_br;

  always @(posedge clk) tick <= tick + 1;

  // Expected output for counter state m (m cycles after reset release);
  // it becomes visible one edge later, at tick base+m+1.
  function automatic exp_t model_state(int m);
    exp_t       e;
    int         slot;
    int         idx;
    logic       on;
    logic [3:0] oh;
    slot = m % 8;
    idx  = (m / 8) % 4;
    on   = (slot >= 1) && ((m % 16) <= f_br) && f_lit[idx];
    oh   = 4'b0001 << idx;
    e.stamp = base + m + 1;
    e.state = m;
    e.digit = on ? ~oh : 4'hF;
    e.seg   = on ? f_seg[idx] : 7'h7F;
    e.dp_n  = on ? f_dpn[idx] : 1'b1;
    e.fs    = ((m % 32) == 0);
    return e;
  endfunction

  task automatic push_reset(input int n);
    exp_t e;
    for (int i = 1; i <= n; i++) begin
      e.stamp = tick + i;
      e.state = -1;
      e.digit = 4'hF;
      e.seg   = 7'h7F;
      e.dp_n  = 1'b1;
      e.fs    = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic wait_state(input int m);
    while ((tick - base) < m) @(negedge clk);
  endtask

  task automatic run_frame(input int f, input logic [27:0] segs, input logic [3:0] dpn,
                           input logic [3:0] lit, input logic lz, input logic [3:0] br,
                           input int last);
    wait_state(32 * f);
    lz_suppress = lz;
    brightness  = br;
    f_br        = int'(br);
    for (int i = 0; i < 4; i++) begin
      f_seg[i] = segs[7*i +: 7];
      f_dpn[i] = dpn[i];
      f_lit[i] = lit[i];
    end
    for (int m = 32 * f; m <= 32 * f + last; m++) q.push_back(model_state(m));
  endtask

  task automatic applyStimulus(input int m, input logic [15:0] v, input logic [3:0] d,
                               input logic [3:0] b);
    wait_state(m);
    value = v;
    dp    = d;
    blank = b;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (digit !== e.digit || seg !== e.seg || dp_n !== e.dp_n || frame_start !== e.fs) begin
      errors++;
      $display("[TB] FAIL state%0d@tick%0d got digit=%h seg=%h dp_n=%b fs=%b want digit=%h seg=%h dp_n=%b fs=%b",
               e.state, e.stamp, digit, seg, dp_n, frame_start, e.digit, e.seg, e.dp_n, e.fs);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].stamp <= tick) begin
        e = q.pop_front();
        if (e.stamp < tick) begin
          checks++;
          errors++;
          $display("[TB] FAIL missed state%0d@tick%0d now tick%0d", e.state, e.stamp, tick);
        end else begin
          checkOutput(e);
        end
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    reset       = 1'b1;
    value       = 16'h0000;
    dp          = 4'h0;
    blank       = 4'h0;
    lz_suppress = 1'b0;
    brightness  = 4'hF;
    load        = 1'b0;
    push_reset(5);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    base  = tick;
    $display("[TB] reset released at tick %0d", base);

    // Frame 0: live still zero; load 12AF mid-frame must not show yet.
    run_frame(0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'hF, 1'b0, 4'hF, 31);
    applyStimulus(9, 16'h12AF, 4'h0, 4'h0);

    run_frame(1, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'hF, 1'b0, 4'hF, 31);
    applyStimulus(40, 16'h0005, 4'h0, 4'h0);

    run_frame(2, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 4'b0001, 1'b1, 4'hF, 31);
    run_frame(3, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 4'hF, 1'b0, 4'hF, 31);

    // Dimmed frame; two loads land in the shadow, only the last may show next frame.
    run_frame(4, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 4'hF, 1'b0, 4'h3, 31);
    applyStimulus(130, 16'h1111, 4'h0, 4'h0);
    applyStimulus(140, 16'h2222, 4'h0, 4'h0);

    run_frame(5, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 4'hF, 1'b0, 4'hF, 31);
    applyStimulus(191, 16'h00C0, 4'b0010, 4'b1000);

    run_frame(6, {7'h7F, 7'h40, 7'h46, 7'h40}, 4'b1101, 4'b0111, 1'b0, 4'hF, 31);
    run_frame(7, {7'h7F, 7'h7F, 7'h46, 7'h40}, 4'b1101, 4'b0011, 1'b1, 4'hF, 31);

    // Abort frame 8 with a mid-frame reset.
    run_frame(8, {7'h7F, 7'h40, 7'h46, 7'h40}, 4'b1101, 4'b0111, 1'b0, 4'hF, 9);
    wait_state(266);
    reset = 1'b1;
    push_reset(3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base  = tick;
    $display("[TB] reset released again at tick %0d", base);

    run_frame(0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'hF, 1'b0, 4'hF, 31);
    wait_state(33);
    repeat (2) @(negedge clk);

    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL unchecked state%0d@tick%0d now tick%0d", e.state, e.stamp, tick);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
